dramctl_pm: RTL and testbench

//  Parametrised successor DRAM controller for the Playground 68030: drives NUM_SIMMS
//  72-pin SIMMs (1 or 2 ranks each) from the CPU bus with configurable RAS/CAS timing.

---
 rtl/dramctl_pm.sv | 227 ++++++++++++++++++++++
 tb/tb_dramctl_pm.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dramctl_pm.sv
// Fast-page-mode DRAM controller for the Playground 68030: row/column muxing, per-SIMM
// rank strobes, queued CAS-before-RAS refresh and DSACK generation for /RAMSEL cycles.
module dramctl_pm #(
  parameter int NUM_SIMMS    = 2,
  parameter int ADDR_W       = 28,
  parameter int T_RCD        = 2,
  parameter int T_CAS        = 2,
  parameter int T_RP         = 2,
  parameter int REFRESH_CNT  = 374,
  parameter int PAGE_MODE    = 1,
  parameter int PAGE_TIMEOUT = 400
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   cpu_nAS,
  input  logic                   cpu_nRAMSEL,
  input  logic                   RnW,
  input  logic [1:0]             SIZ,
  input  logic [ADDR_W-1:0]      ADDR,
  input  logic                   SIMMSZ,
  output logic                   DRAM_nWR,
  output logic [11:0]            DRAM_ADDR,
  output logic [4*NUM_SIMMS-1:0] DRAM_nRAS,
  output logic [3:0]             DRAM_nCAS,
  output logic                   DSACK0,
  output logic                   DSACK1
);

  typedef enum logic [3:0] {
    IDLE, ROW, RAS, COL, CAS, ACK, OPEN, PRE, REF1, REF2, REF3, REF4
  } state_t;

  localparam int SW = ADDR_W - 27;
  localparam int RW = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
  localparam logic [15:0]   RCD_LAST  = 16'(T_RCD - 1);
  localparam logic [15:0]   CAS_LAST  = 16'(T_CAS - 1);
  localparam logic [15:0]   RP_LAST   = 16'(T_RP - 1);
  localparam logic [15:0]   PAGE_LAST = 16'(PAGE_TIMEOUT - 1);
  localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_CNT - 1);

  state_t                 state, state_next;
  logic [15:0]            dwell;
  logic                   as_meta, as_sync, sel_meta, sel_sync, req;
  logic [RW-1:0]          ref_cnt;
  logic                   ref_tick, ref_take;
  logic [1:0]             pending;
  logic [11:0]            row_addr, col_addr;
  logic                   rank_in;
  logic [SW-1:0]          simm_in;
  logic [2:0]             be_first, be_last;
  logic [3:0]             be_in, be_q;
  logic [SW-1:0]          tag_simm;
  logic                   tag_rank;
  logic [11:0]            tag_row;
  logic                   hit;
  logic [4*NUM_SIMMS-1:0] ras_mask, ras_next;
  logic [3:0]             cas_next;
  logic [11:0]            addr_next;
  logic                   nwr_next, dsack_next, dsack;

  // Sync flops hold the asserted (active-high) sense so reset means "not requested".
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      as_meta  <= 1'b0;
      as_sync  <= 1'b0;
      sel_meta <= 1'b0;
      sel_sync <= 1'b0;
    end else begin
      as_meta  <= ~cpu_nAS;
      as_sync  <= as_meta;
      sel_meta <= ~cpu_nRAMSEL;
      sel_sync <= sel_meta;
    end
  end

  assign req = as_sync & sel_sync;

  always_comb begin
    simm_in = ADDR[ADDR_W-1:27];
    if (SIMMSZ) begin
      row_addr = {1'b0, ADDR[12:2]};
      col_addr = {1'b0, ADDR[23:13]};
      rank_in  = ADDR[24];
    end else begin
      row_addr = ADDR[13:2];
      col_addr = ADDR[25:14];
      rank_in  = ADDR[26];
    end
    // Big-endian bus: byte offset 0 lands on D31:24, i.e. enable bit 3.
    be_first = {1'b0, ADDR[1:0]};
    be_last  = be_first + ((SIZ == 2'b00) ? 3'd3 : ({1'b0, SIZ} - 3'd1));
    be_in    = 4'b0000;
    for (int k = 0; k < 4; k++)
      be_in[3-k] = (3'(k) >= be_first) && (3'(k) <= be_last);
    hit = (simm_in == tag_simm) && (rank_in == tag_rank) && (row_addr == tag_row);
  end

  always_comb begin
    ras_mask = '0;
    for (int i = 0; i < NUM_SIMMS; i++)
      if (tag_simm == SW'(i))
        ras_mask[4*i +: 4] = tag_rank ? 4'b1010 : 4'b0101;
  end

  assign ref_tick = (ref_cnt == REF_LAST);
  assign ref_take = (state == REF1);

  // A tick and a take landing together cancel, so the queue depth stays put.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ref_cnt <= '0;
      pending <= 2'd0;
    end else begin
      ref_cnt <= ref_tick ? '0 : ref_cnt + 1'b1;
      if (ref_tick && !ref_take && pending != 2'd3)
        pending <= pending + 2'd1;
      else if (!ref_tick && ref_take)
        pending <= pending - 2'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      dwell <= '0;
    end else begin
      state <= state_next;
      dwell <= (state_next != state) ? '0 : dwell + 16'd1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (pending != 2'd0) state_next = REF1;
            else if (req)        state_next = ROW;
      ROW:  state_next = RAS;
      RAS:  if (dwell == RCD_LAST) state_next = COL;
      COL:  state_next = CAS;
      CAS:  if (dwell == CAS_LAST) state_next = ACK;
      ACK:  if (!as_sync) state_next = (PAGE_MODE != 0) ? OPEN : PRE;
      OPEN: if (pending != 2'd0 || dwell == PAGE_LAST) state_next = PRE;
            else if (req) state_next = hit ? COL : PRE;
      PRE:  if (dwell == RP_LAST) state_next = IDLE;
      REF1: state_next = REF2;
      REF2: state_next = REF3;
      REF3: state_next = REF4;
      REF4: state_next = PRE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so every strobe changes cleanly on CLK.
  always_comb begin
    ras_next   = '1;
    cas_next   = 4'hF;
    nwr_next   = 1'b1;
    addr_next  = DRAM_ADDR;
    dsack_next = 1'b0;
    case (state_next)
      ROW:  addr_next = row_addr;
      RAS:  ras_next  = ~ras_mask;
      COL: begin
        ras_next  = ~ras_mask;
        addr_next = col_addr;
        nwr_next  = RnW;
      end
      CAS: begin
        ras_next = ~ras_mask;
        cas_next = ~be_q;
        nwr_next = DRAM_nWR;
      end
      ACK: begin
        ras_next   = ~ras_mask;
        cas_next   = ~be_q;
        nwr_next   = DRAM_nWR;
        dsack_next = 1'b1;
      end
      OPEN: ras_next  = ~ras_mask;
      PRE:  addr_next = '0;
      REF1: cas_next  = 4'h0;
      REF2: begin
        cas_next = 4'h0;
        ras_next = '0;
      end
      REF3: ras_next = '0;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      tag_simm <= '0;
      tag_rank <= 1'b0;
      tag_row  <= '0;
      be_q     <= 4'h0;
    end else begin
      if (state == IDLE && state_next == ROW) begin
        tag_simm <= simm_in;
        tag_rank <= rank_in;
        tag_row  <= row_addr;
      end
      if (state != COL && state_next == COL)
        be_q <= RnW ? 4'hF : be_in;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      DRAM_nRAS <= '1;
      DRAM_nCAS <= 4'hF;
      DRAM_nWR  <= 1'b1;
      DRAM_ADDR <= '0;
      dsack     <= 1'b0;
    end else begin
      DRAM_nRAS <= ras_next;
      DRAM_nCAS <= cas_next;
      DRAM_nWR  <= nwr_next;
      DRAM_ADDR <= addr_next;
      dsack     <= dsack_next;
    end
  end

  assign DSACK0 = dsack;
  assign DSACK1 = dsack;

endmodule

// File: tb/tb_dramctl_pm.sv
// Directed bench for dramctl_pm: mapping, byte enables, page hits/misses, reset
// mid-cycle, and queued/saturating refresh, checked with immediate assertions.
module tb_dramctl_pm;
  localparam int T_RCD       = 2;
  localparam int T_CAS       = 2;
  localparam int T_RP        = 2;
  localparam int REFRESH_CNT = 374;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        cpu_nAS = 1'b1;
  logic        cpu_nRAMSEL = 1'b1;
  logic        RnW = 1'b1;
  logic [1:0]  SIZ = 2'b00;
  logic [27:0] ADDR = '0;
  logic        SIMMSZ = 1'b1;
  logic        DRAM_nWR;
  logic [11:0] DRAM_ADDR;
  logic [7:0]  DRAM_nRAS;
  logic [3:0]  DRAM_nCAS;
  logic        DSACK0, DSACK1;

  int          compared = 0;
  int          mismatched = 0;
  int          since_rst = 0;
  int          lat, ras_high, ref1_seen, ref2_seen;
  logic        ras_moved, nwr_at_ack, dsack1_at_ack;
  logic [3:0]  cas_at_ack;
  logic [7:0]  ras_at_ack;
  logic [11:0] row_seen, col_seen;

  dramctl_pm #(
    .NUM_SIMMS(2), .ADDR_W(28), .T_RCD(T_RCD), .T_CAS(T_CAS), .T_RP(T_RP),
    .REFRESH_CNT(REFRESH_CNT), .PAGE_MODE(1), .PAGE_TIMEOUT(400)
  ) dut (
    .CLK(CLK), .nRST(nRST), .cpu_nAS(cpu_nAS), .cpu_nRAMSEL(cpu_nRAMSEL),
    .RnW(RnW), .SIZ(SIZ), .ADDR(ADDR), .SIMMSZ(SIMMSZ),
    .DRAM_nWR(DRAM_nWR), .DRAM_ADDR(DRAM_ADDR), .DRAM_nRAS(DRAM_nRAS),
    .DRAM_nCAS(DRAM_nCAS), .DSACK0(DSACK0), .DSACK1(DSACK1)
  );

  always #10 CLK = ~CLK;

  always @(posedge CLK or negedge nRST)
    if (!nRST) since_rst <= 0;
    else       since_rst <= since_rst + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Starts a CPU cycle on a falling edge and counts falling edges until DSACK.
  task automatic applyStimulus(input logic [27:0] a, input logic rnw, input logic [1:0] siz,
                               input logic sz, input bit hold_as);
    logic [7:0] prev;
    int n;
    @(negedge CLK);
    ADDR = a; RnW = rnw; SIZ = siz; SIMMSZ = sz;
    cpu_nAS = 1'b0; cpu_nRAMSEL = 1'b0;
    lat = 0; ras_high = 0; ras_moved = 1'b0; row_seen = '0;
    prev = DRAM_nRAS;
    while (!DSACK0 && lat < 60) begin
      @(negedge CLK);
      lat++;
      if (DRAM_nRAS != prev) ras_moved = 1'b1;
      if (DRAM_nRAS == 8'hFF) ras_high++;
      if (prev == 8'hFF && DRAM_nRAS != 8'hFF) row_seen = DRAM_ADDR;
      prev = DRAM_nRAS;
    end
    checkOutput("dsack_seen", DSACK0, 1'b1);
    cas_at_ack = DRAM_nCAS; nwr_at_ack = DRAM_nWR; ras_at_ack = DRAM_nRAS;
    col_seen = DRAM_ADDR; dsack1_at_ack = DSACK1;
    if (!hold_as) begin
      cpu_nAS = 1'b1; cpu_nRAMSEL = 1'b1;
      n = 0;
      while (DSACK0 && n < 20) begin
        @(negedge CLK);
        n++;
      end
      checkOutput("dsack_release", DSACK0, 1'b0);
      repeat (2) @(negedge CLK);
    end
  endtask

  task automatic pulse_reset();
    cpu_nAS = 1'b1; cpu_nRAMSEL = 1'b1;
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge CLK);
    checkOutput("rst_nras", DRAM_nRAS, 8'hFF);
    checkOutput("rst_ncas", DRAM_nCAS, 4'hF);
    checkOutput("rst_nwr", DRAM_nWR, 1'b1);
    checkOutput("rst_addr", DRAM_ADDR, 12'h000);
    checkOutput("rst_dsack0", DSACK0, 1'b0);
    checkOutput("rst_dsack1", DSACK1, 1'b0);
    nRST = 1'b1;
    @(negedge CLK);

    // SIMM0 rank0, 11-bit: row 0x123, col 0x2AB; miss from IDLE.
    applyStimulus(28'h055648C, 1'b1, 2'b00, 1'b1, 1'b0);
    checkOutput("rd_latency", lat, 5 + T_RCD + T_CAS);
    checkOutput("rd_nras", ras_at_ack, 8'hFA);
    checkOutput("rd_ncas", cas_at_ack, 4'h0);
    checkOutput("rd_nwr", nwr_at_ack, 1'b1);
    checkOutput("rd_row", row_seen, 12'h123);
    checkOutput("rd_col", col_seen, 12'h2AB);
    checkOutput("rd_dsack1", dsack1_at_ack, 1'b1);

    applyStimulus(28'h000248C, 1'b1, 2'b00, 1'b1, 1'b0);
    checkOutput("hit_latency", lat, 4 + T_CAS);
    checkOutput("hit_ras_still", ras_moved, 1'b0);
    checkOutput("hit_col", col_seen, 12'h001);
    checkOutput("hit_nras", ras_at_ack, 8'hFA);

    applyStimulus(28'h000248E, 1'b0, 2'b01, 1'b1, 1'b0);
    checkOutput("byte_wr_ncas", cas_at_ack, 4'b1101);
    checkOutput("byte_wr_nwr", nwr_at_ack, 1'b0);
    applyStimulus(28'h000248D, 1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("long_wr01_ncas", cas_at_ack, 4'b1000);
    checkOutput("long_wr01_nwr", nwr_at_ack, 1'b0);
    applyStimulus(28'h000248F, 1'b0, 2'b10, 1'b1, 1'b0);
    checkOutput("word_wr11_ncas", cas_at_ack, 4'b1110);
    applyStimulus(28'h000248C, 1'b0, 2'b11, 1'b1, 1'b0);
    checkOutput("tri_wr00_ncas", cas_at_ack, 4'b0001);

    // SIMM1 rank1 row 0x055: page miss goes through precharge first.
    applyStimulus(28'h9000154, 1'b1, 2'b00, 1'b1, 1'b0);
    checkOutput("miss_latency", lat, 5 + T_RCD + T_CAS + 1 + T_RP);
    checkOutput("miss_ras_high", ras_high, T_RP + 2);
    checkOutput("miss_nras", ras_at_ack, 8'h5F);
    checkOutput("miss_row", row_seen, 12'h055);

    // 12-bit SIMM: row 0xABC, col 0x9F1, rank1 of SIMM0.
    applyStimulus(28'h67C6AF0, 1'b1, 2'b00, 1'b0, 1'b0);
    checkOutput("wide_nras", ras_at_ack, 8'hF5);
    checkOutput("wide_row", row_seen, 12'hABC);
    checkOutput("wide_col", col_seen, 12'h9F1);

    @(negedge CLK);
    ADDR = 28'h055648C; RnW = 1'b1; SIZ = 2'b00; SIMMSZ = 1'b1;
    cpu_nAS = 1'b0; cpu_nRAMSEL = 1'b0;
    n = 0;
    while (DRAM_nCAS == 4'hF && n < 40) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("cas_before_reset", DRAM_nCAS, 4'h0);
    #2 nRST = 1'b0;
    #1;
    checkOutput("midrst_nras", DRAM_nRAS, 8'hFF);
    checkOutput("midrst_ncas", DRAM_nCAS, 4'hF);
    checkOutput("midrst_dsack0", DSACK0, 1'b0);
    checkOutput("midrst_dsack1", DSACK1, 1'b0);
    checkOutput("midrst_nwr", DRAM_nWR, 1'b1);
    cpu_nAS = 1'b1; cpu_nRAMSEL = 1'b1;
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    applyStimulus(28'h055648C, 1'b1, 2'b00, 1'b1, 1'b0);
    checkOutput("post_rst_latency", lat, 5 + T_RCD + T_CAS);
    checkOutput("post_rst_nras", ras_at_ack, 8'hFA);

    // Page left open while refresh comes due three times.
    checkOutput("page_open_idle", DRAM_nRAS, 8'hFA);
    ref1_seen = 0; ref2_seen = 0;
    while (since_rst < 3 * REFRESH_CNT + 30) begin
      @(negedge CLK);
      if (DRAM_nRAS == 8'hFF && DRAM_nCAS == 4'h0) ref1_seen++;
      if (DRAM_nRAS == 8'h00 && DRAM_nCAS == 4'h0) ref2_seen++;
    end
    checkOutput("cbr_cas_first", ref1_seen, 3);
    checkOutput("cbr_count", ref2_seen, 3);
    checkOutput("page_closed_nras", DRAM_nRAS, 8'hFF);
    checkOutput("page_closed_ncas", DRAM_nCAS, 4'hF);
    checkOutput("pending_drained", dut.pending, 2'd0);

    // Hold a cycle in ACK across four refresh intervals: queue saturates at 3.
    pulse_reset();
    applyStimulus(28'h055648C, 1'b1, 2'b00, 1'b1, 1'b1);
    while (since_rst < 4 * REFRESH_CNT + 40) @(negedge CLK);
    checkOutput("ack_held", DSACK0, 1'b1);
    checkOutput("cas_held", DRAM_nCAS, 4'h0);
    cpu_nAS = 1'b1; cpu_nRAMSEL = 1'b1;
    ref2_seen = 0;
    repeat (200) begin
      @(negedge CLK);
      if (DRAM_nRAS == 8'h00 && DRAM_nCAS == 4'h0) ref2_seen++;
    end
    checkOutput("sat_cbr_count", ref2_seen, 3);
    checkOutput("sat_pending", dut.pending, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: run exceeded time limit, compared=%0d", compared);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
